// File: rtl/game_board_n.sv
// rtl/game_board_n.sv - N x N two-player board: pixel hit test, move commit FSM, win/draw detection
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset
//   button     asynchronous move-commit pushbutton (active high)
//   switches   cell select, bit i = row i/N, column i%N
//   x, y       current pixel coordinate
//   lx, ly     pixel offset inside the hit cell (0 outside any cell)
//   mode       occupancy of the hit cell: 00 empty, 01 X, 10 O
//   square     pixel lies inside a cell
//   highlight  pixel lies inside a selected cell or a winning-line cell
//   turn       player to move: 0 X, 1 O
//   status     00 play, 01 win, 10 draw
//   winner     winning player, meaningful in win
//   bad_move   one-cycle pulse on a rejected move request
module game_board_n #(
  parameter int N   = 3,
  parameter int SQ  = 128,
  parameter int GAP = 16,
  parameter int X0  = 112,
  parameter int Y0  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           button,
  input  logic [N*N-1:0] switches,
  input  logic [9:0]     x,
  input  logic [9:0]     y,
  output logic [9:0]     lx,
  output logic [9:0]     ly,
  output logic [1:0]     mode,
  output logic           square,
  output logic           highlight,
  output logic           turn,
  output logic [1:0]     status,
  output logic           winner,
  output logic           bad_move
);

  localparam int NC = N * N;
  localparam int P  = SQ + GAP;
  localparam int CW = $clog2(NC + 1);

  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_WIN, S_DRAW} state_t;

  state_t               state, state_nx;
  logic [NC-1:0][1:0]   board;
  logic [CW-1:0]        count;
  logic [NC-1:0]        win_mask;

  logic sync1, sync2, sync_q, live1, live2, armed, req_q;

  // Button synchronizer and rising-edge detector. 'armed' only rises once the
  // synchronized button has been seen low after reset, so a button held
  // through reset release cannot masquerade as a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_q <= 1'b0;
      live1  <= 1'b0;
      live2  <= 1'b0;
      armed  <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      sync1  <= button;
      sync2  <= sync1;
      sync_q <= sync2;
      live1  <= 1'b1;
      live2  <= live1;
      armed  <= armed | (live2 & ~sync2);
      req_q  <= sync2 & ~sync_q & armed;
    end
  end

  // Move legality: exactly one switch set and that cell is still empty.
  logic [NC-1:0] occ;
  logic          onehot, legal, accept, reject;
  logic [1:0]    code;

  always_comb begin
    for (int i = 0; i < NC; i++) occ[i] = |board[i];
  end

  assign onehot = (switches != '0) && ((switches & (switches - NC'(1))) == '0);
  assign legal  = onehot && ((switches & occ) == '0);
  assign accept = (state == S_PLAY) && req_q && legal;
  assign reject = (state == S_PLAY) && req_q && !legal;
  assign code   = turn ? 2'b10 : 2'b01;

  // Lines owned by the player who just moved; the mask is the union of every
  // complete line so a double win highlights both.
  logic          has_line, full;
  logic [NC-1:0] line_mask;

  always_comb begin
    has_line  = 1'b0;
    line_mask = '0;
    full      = 1'b0;
    for (int r = 0; r < N; r++) begin
      full = 1'b1;
      for (int c = 0; c < N; c++) if (board[r*N+c] != code) full = 1'b0;
      if (full) begin
        has_line = 1'b1;
        for (int c = 0; c < N; c++) line_mask[r*N+c] = 1'b1;
      end
    end
    for (int c = 0; c < N; c++) begin
      full = 1'b1;
      for (int r = 0; r < N; r++) if (board[r*N+c] != code) full = 1'b0;
      if (full) begin
        has_line = 1'b1;
        for (int r = 0; r < N; r++) line_mask[r*N+c] = 1'b1;
      end
    end
    full = 1'b1;
    for (int i = 0; i < N; i++) if (board[i*N+i] != code) full = 1'b0;
    if (full) begin
      has_line = 1'b1;
      for (int i = 0; i < N; i++) line_mask[i*N+i] = 1'b1;
    end
    full = 1'b1;
    for (int i = 0; i < N; i++) if (board[i*N+(N-1-i)] != code) full = 1'b0;
    if (full) begin
      has_line = 1'b1;
      for (int i = 0; i < N; i++) line_mask[i*N+(N-1-i)] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_PLAY;
    else      state <= state_nx;
  end

  // FSM next state; WIN and DRAW only leave through reset
  always_comb begin
    state_nx = state;
    case (state)
      S_PLAY:  if (accept) state_nx = S_CHECK;
      S_CHECK: begin
        if (has_line)                state_nx = S_WIN;
        else if (count == CW'(NC))   state_nx = S_DRAW;
        else                         state_nx = S_PLAY;
      end
      default: state_nx = state;
    endcase
  end

  // Board, move counter, turn and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board    <= '0;
      count    <= '0;
      turn     <= 1'b0;
      winner   <= 1'b0;
      win_mask <= '0;
      bad_move <= 1'b0;
    end else begin
      bad_move <= reject;
      if (accept) begin
        for (int i = 0; i < NC; i++) if (switches[i]) board[i] <= code;
        count <= count + CW'(1);
      end
      if (state == S_CHECK) begin
        if (has_line) begin
          winner   <= turn;
          win_mask <= line_mask;
        end else if (count != CW'(NC)) begin
          turn <= ~turn;
        end
      end
    end
  end

  // Pixel hit test: compared in 32-bit arithmetic so no coordinate can wrap.
  logic [N-1:0] row_hit, col_hit;
  logic [9:0]   lx_c, ly_c;

  always_comb begin
    row_hit = '0;
    col_hit = '0;
    lx_c    = '0;
    ly_c    = '0;
    for (int c = 0; c < N; c++) begin
      if (int'(x) >= X0 + c*P && int'(x) < X0 + c*P + SQ) begin
        col_hit[c] = 1'b1;
        lx_c       = 10'(int'(x) - (X0 + c*P));
      end
    end
    for (int r = 0; r < N; r++) begin
      if (int'(y) >= Y0 + r*P && int'(y) < Y0 + r*P + SQ) begin
        row_hit[r] = 1'b1;
        ly_c       = 10'(int'(y) - (Y0 + r*P));
      end
    end
  end

  // FSM / pixel outputs
  always_comb begin
    status    = 2'b00;
    square    = (|row_hit) & (|col_hit);
    mode      = 2'b00;
    highlight = 1'b0;
    lx        = '0;
    ly        = '0;
    case (state)
      S_WIN:   status = 2'b01;
      S_DRAW:  status = 2'b10;
      default: status = 2'b00;
    endcase
    if (square) begin
      lx = lx_c;
      ly = ly_c;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (row_hit[r] && col_hit[c]) begin
            mode      = board[r*N+c];
            highlight = switches[r*N+c] | ((state == S_WIN) & win_mask[r*N+c]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_game_board_n.sv
// tb/tb_game_board_n.sv - randomized self-checking bench for game_board_n (N=3 and N=4 instances)
`timescale 1ns/1ps
module tb_game_board_n;

  localparam int SQ = 128, GAP = 16, X0 = 112, Y0 = 32, P = SQ + GAP;

  logic        clk = 1'b0, rst = 1'b0, btn3 = 1'b0, btn4 = 1'b0;
  logic [15:0] sw = '0;
  logic [9:0]  px = '0, py = '0;
  logic [9:0]  lx3, ly3, lx4, ly4;
  logic [1:0]  mode3, mode4, status3, status4;
  logic        sq3, sq4, hl3, hl4, turn3, turn4, win3, win4, bad3, bad4;

  int n_cmp = 0, n_err = 0, bad3_cnt = 0, bad4_cnt = 0, cur_n = 3;

  // reference model: cell owners 0/1/2, winning-cell marks, game scalars
  int mb[25];
  int mmask[25];
  int m_turn, m_count, m_status, m_winner, exp_bad;

  game_board_n #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .button(btn3), .switches(sw[8:0]), .x(px), .y(py),
    .lx(lx3), .ly(ly3), .mode(mode3), .square(sq3), .highlight(hl3),
    .turn(turn3), .status(status3), .winner(win3), .bad_move(bad3));

  game_board_n #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .button(btn4), .switches(sw), .x(px), .y(py),
    .lx(lx4), .ly(ly4), .mode(mode4), .square(sq4), .highlight(hl4),
    .turn(turn4), .status(status4), .winner(win4), .bad_move(bad4));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bad3) bad3_cnt <= bad3_cnt + 1;
    if (bad4) bad4_cnt <= bad4_cnt + 1;
  end

  logic [9:0] o_lx, o_ly;
  logic [1:0] o_mode, o_status;
  logic       o_sq, o_hl, o_turn, o_win;
  int         o_badcnt;

  always_comb begin
    if (cur_n == 3) begin
      o_lx = lx3; o_ly = ly3; o_mode = mode3; o_status = status3;
      o_sq = sq3; o_hl = hl3; o_turn = turn3; o_win = win3; o_badcnt = bad3_cnt;
    end else begin
      o_lx = lx4; o_ly = ly4; o_mode = mode4; o_status = status4;
      o_sq = sq4; o_hl = hl4; o_turn = turn4; o_win = win4; o_badcnt = bad4_cnt;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int line_cell(input int n, input int k, input int i);
    if (k < n)           return k*n + i;
    else if (k < 2*n)    return i*n + (k - n);
    else if (k == 2*n)   return i*n + i;
    else                 return i*n + (n - 1 - i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 25; i++) begin mb[i] = 0; mmask[i] = 0; end
    m_turn = 0; m_count = 0; m_status = 0; m_winner = 0; exp_bad = 0;
  endtask

  task automatic model_press(input logic [15:0] s);
    int cnt, idx, code, nn, win, own;
    nn = cur_n * cur_n; exp_bad = 0; cnt = 0; idx = 0;
    if (m_status != 0) return;
    for (int i = 0; i < nn; i++) if (s[i]) begin cnt++; idx = i; end
    if (cnt != 1 || mb[idx] != 0) begin exp_bad = 1; return; end
    code = m_turn + 1;
    mb[idx] = code;
    m_count++;
    win = 0;
    for (int k = 0; k < 2*cur_n + 2; k++) begin
      own = 1;
      for (int i = 0; i < cur_n; i++) if (mb[line_cell(cur_n, k, i)] != code) own = 0;
      if (own == 1) begin
        win = 1;
        for (int i = 0; i < cur_n; i++) mmask[line_cell(cur_n, k, i)] = 1;
      end
    end
    if (win == 1) begin m_status = 1; m_winner = m_turn; end
    else if (m_count == nn) m_status = 2;
    else m_turn ^= 1;
  endtask

  task automatic pix_model(input int xx, input int yy, output bit in,
                           output int idx, output int ox, output int oy);
    int dx, dy;
    in = 0; idx = 0; ox = 0; oy = 0;
    if (xx < X0 || yy < Y0) return;
    dx = xx - X0; dy = yy - Y0;
    if (dx / P >= cur_n || dy / P >= cur_n || dx % P >= SQ || dy % P >= SQ) return;
    in = 1; idx = (dy / P) * cur_n + dx / P; ox = dx % P; oy = dy % P;
  endtask

  task automatic check_pixels(input int k);
    bit in; int idx, ox, oy, eh;
    for (int i = 0; i < k; i++) begin
      if (i % 2 == 0) begin
        px = 10'($urandom_range(0, 1023));
        py = 10'($urandom_range(0, 1023));
      end else begin
        px = 10'(X0 + $urandom_range(0, cur_n) * P + $urandom_range(0, P) - 1);
        py = 10'(Y0 + $urandom_range(0, cur_n) * P + $urandom_range(0, P) - 1);
      end
      #1;
      pix_model(int'(px), int'(py), in, idx, ox, oy);
      eh = (in && (sw[idx] || (m_status == 1 && mmask[idx] != 0))) ? 1 : 0;
      check_eq("pix_square", o_sq, in);
      check_eq("pix_mode", o_mode, in ? mb[idx] : 0);
      check_eq("pix_lx", o_lx, ox);
      check_eq("pix_ly", o_ly, oy);
      check_eq("pix_highlight", o_hl, eh);
    end
  endtask

  task automatic check_board();
    for (int r = 0; r < cur_n; r++) begin
      for (int c = 0; c < cur_n; c++) begin
        px = 10'(X0 + c*P + $urandom_range(0, SQ-1));
        py = 10'(Y0 + r*P + $urandom_range(0, SQ-1));
        #1;
        check_eq("cell_mode", o_mode, mb[r*cur_n + c]);
      end
    end
  endtask

  task automatic check_game();
    check_eq("status", o_status, m_status);
    check_eq("turn", o_turn, m_turn);
    check_eq("winner", o_win, m_winner);
    check_board();
  endtask

  task automatic press(input logic [15:0] s);
    int b0;
    b0 = o_badcnt;
    sw = s;
    if (cur_n == 3) btn3 = 1'b1; else btn4 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    btn3 = 1'b0; btn4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    model_press(s);
    check_eq("bad_pulse", o_badcnt - b0, exp_bad);
    check_game();
    check_pixels(10);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; btn3 = 1'b0; btn4 = 1'b0; sw = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cur_n = n;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_game();
  endtask

  task automatic random_game(input int n, input int presses);
    logic [15:0] s, nmask;
    int r;
    nmask = 16'((32'd1 << (n*n)) - 1);
    do_reset(n);
    for (int k = 0; k < presses; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      s = 16'(32'd1 << $urandom_range(0, n*n - 1));
      else if (r < 7) s = '0;
      else            s = 16'($urandom) & nmask;
      press(s);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset(3);

    // fixed hit-test points on the 3x3 board
    px = 112; py = 32;  #1;
    check_eq("hit_origin_sq", o_sq, 1);
    check_eq("hit_origin_lx", o_lx, 0);
    check_eq("hit_origin_ly", o_ly, 0);
    px = 240; py = 32;  #1;
    check_eq("hit_gap_sq", o_sq, 0);
    px = 111; py = 32;  #1;
    check_eq("hit_left_sq", o_sq, 0);
    px = 256; py = 176; #1;
    check_eq("hit_cell4_sq", o_sq, 1);
    check_eq("hit_cell4_lx", o_lx, 0);
    sw = 16'h010; #1;
    check_eq("hit_cell4_hl", o_hl, 1);
    sw = 16'h000; #1;

    // first move latency: cell 0 becomes X on the fourth edge after the press
    px = 112; py = 32; sw = 16'h001;
    @(posedge clk); #1;
    btn3 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_eq("lat_early_mode", o_mode, 0);
    @(posedge clk); #1;
    check_eq("lat_cell_mode", o_mode, 1);
    @(posedge clk); #1;
    check_eq("lat_turn", o_turn, 1);
    check_eq("lat_status", o_status, 0);
    repeat (6) @(posedge clk); #1;
    btn3 = 1'b0;
    repeat (4) @(posedge clk); #1;
    model_press(16'h001);
    check_game();
    press(16'h001);
    check_eq("repeat_bad_turn", o_turn, 1);
    press(16'h003);

    // diagonal win for X
    do_reset(3);
    press(16'h001); press(16'h002); press(16'h010); press(16'h004); press(16'h100);
    check_eq("diag_status", o_status, 1);
    check_eq("diag_winner", o_win, 0);
    sw = '0;
    for (int i = 0; i < 9; i++) begin
      px = 10'(X0 + (i % 3) * P + 60);
      py = 10'(Y0 + (i / 3) * P + 60);
      #1;
      check_eq("diag_highlight", o_hl, (i == 0 || i == 4 || i == 8) ? 1 : 0);
    end
    press(16'h040);

    // full board with no line -> draw, then requests ignored
    do_reset(3);
    press(16'h001); press(16'h002); press(16'h004); press(16'h010); press(16'h008);
    press(16'h020); press(16'h080); press(16'h040); press(16'h100);
    check_eq("draw_status", o_status, 2);
    press(16'h001);
    press(16'h000);

    // reset while in CHECK abandons the move
    do_reset(3);
    sw = 16'h010;
    btn3 = 1'b1;
    repeat (4) @(posedge clk); #1;
    rst = 1'b0; #1;
    check_eq("midcheck_turn", o_turn, 0);
    repeat (2) @(posedge clk); #1;
    btn3 = 1'b0; rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    model_reset();
    check_game();
    press(16'h010);

    // button held through reset release must not commit a move
    rst = 1'b0; btn3 = 1'b1; sw = 16'h001;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (8) @(posedge clk); #1;
    check_game();
    btn3 = 1'b0;
    repeat (4) @(posedge clk); #1;
    press(16'h001);

    for (int g = 0; g < 4; g++) random_game(3, 16);

    // 4x4: O completes column 3, then asynchronous reset clears everything
    do_reset(4);
    press(16'h0001); press(16'h0008); press(16'h0002); press(16'h0080);
    press(16'h0010); press(16'h0800); press(16'h0100); press(16'h8000);
    check_eq("col3_status", o_status, 1);
    check_eq("col3_winner", o_win, 1);
    px = 10'(X0 + 3*P + 5); py = 10'(Y0 + 5); sw = '0;
    @(negedge clk); #1;
    rst = 1'b0; #1;
    check_eq("arst_status", o_status, 0);
    check_eq("arst_winner", o_win, 0);
    check_eq("arst_turn", o_turn, 0);
    check_eq("arst_mode", o_mode, 0);
    check_eq("arst_highlight", o_hl, 0);
    check_eq("arst_bad", bad4, 0);

    do_reset(4);
    press(16'h0001); press(16'h0002); press(16'h0004);
    @(negedge clk); #1;
    rst = 1'b0; #1;
    check_eq("arst_mid_turn", o_turn, 0);
    px = 10'(X0 + 5); py = 10'(Y0 + 5); #1;
    check_eq("arst_mid_mode", o_mode, 0);

    random_game(4, 24);
    random_game(4, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
